// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one of num_req requesters own a FIFO write port
// for up to `burst` accepted beats per tenure.
module fifo_wr_arbiter #(
  parameter int width   = 8,
  parameter int num_req = 4,
  parameter int burst   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [num_req-1:0]         req_i,
  input  logic [num_req*width-1:0]   data_i,
  output logic [num_req-1:0]         gnt_o,
  input  logic                       full_i,
  output logic                       wr_en_o,
  output logic [width-1:0]           din_o,
  output logic [$clog2(num_req)-1:0] owner_o,
  output logic                       busy_o
);

  localparam int ow = $clog2(num_req);
  localparam logic [ow-1:0]      last_idx   = ow'(num_req - 1);
  localparam logic [3:0]         burst_last = 4'(burst - 1);
  localparam logic [num_req-1:0] gnt_one    = {{(num_req-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_r;
  logic [ow-1:0]        owner_r;
  logic [ow-1:0]        last_owner_r;
  logic [num_req-1:0]   gnt_r;
  logic                 busy_r;
  logic [3:0]           beat_cnt_r;

  logic                 accept_s;
  logic                 tenure_end_s;
  logic                 pick_valid_s;
  logic [ow-1:0]        pick_idx_s;
  logic [ow-1:0]        pick_base_s;

  // Search starts just after base and wraps, so base itself is checked last.
  function automatic logic [ow:0] rr_pick(input logic [num_req-1:0] req,
                                          input logic [ow-1:0]      base);
    logic [ow:0]   res;
    logic [ow-1:0] idx;
    res = {(ow+1){1'b0}};
    for (int i = num_req; i >= 1; i--) begin
      idx = ow'((int'(base) + i) % num_req);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Beat acceptance, tenure end and next-owner selection.
  always_comb begin
    pick_base_s  = (state_r == GRANT) ? owner_r : last_owner_r;
    {pick_valid_s, pick_idx_s} = rr_pick(req_i, pick_base_s);
    accept_s     = (state_r == GRANT) && req_i[owner_r] && !full_i;
    tenure_end_s = (state_r == GRANT) &&
                   (!req_i[owner_r] || (accept_s && (beat_cnt_r == burst_last)));
  end

  // FIFO write path follows the accepted beat in the same cycle.
  always_comb begin
    wr_en_o = accept_s;
    if (accept_s) begin
      din_o = data_i[int'(owner_r)*width +: width];
    end else begin
      din_o = {width{1'b0}};
    end
  end

  // Ownership FSM with registered grant outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      owner_r      <= {ow{1'b0}};
      last_owner_r <= last_idx;
      gnt_r        <= {num_req{1'b0}};
      busy_r       <= 1'b0;
      beat_cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            state_r    <= GRANT;
            owner_r    <= pick_idx_s;
            gnt_r      <= gnt_one << pick_idx_s;
            busy_r     <= 1'b1;
            beat_cnt_r <= 4'd0;
          end
        end
        GRANT: begin
          if (tenure_end_s) begin
            last_owner_r <= owner_r;
            beat_cnt_r   <= 4'd0;
            // Hand over back-to-back when anyone (including the owner) still asks.
            if (pick_valid_s) begin
              owner_r <= pick_idx_s;
              gnt_r   <= gnt_one << pick_idx_s;
            end else begin
              state_r <= IDLE;
              owner_r <= {ow{1'b0}};
              gnt_r   <= {num_req{1'b0}};
              busy_r  <= 1'b0;
            end
          end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          owner_r    <= {ow{1'b0}};
          gnt_r      <= {num_req{1'b0}};
          busy_r     <= 1'b0;
          beat_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_r;
  assign owner_o = owner_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario, hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           full;
  logic           wr_en;
  logic [W-1:0]   din;
  logic [1:0]     owner;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.width(W), .num_req(N), .burst(B)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .req_i    (req),
    .data_i   (data),
    .gnt_o    (gnt),
    .full_i   (full),
    .wr_en_o  (wr_en),
    .din_o    (din),
    .owner_o  (owner),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    full    = 1'b0;
    data    = 32'h0;
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b1111;
    full    = 1'b0;
    data    = 32'h44332211;
    #1;
    n_checks++;
    if ({gnt, wr_en, din, owner, busy} !== {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: gnt=%b wr_en=%b din=%h owner=%0d busy=%b, want all zero",
               gnt, wr_en, din, owner, busy);
    end
    repeat (2) next_cycle();
    n_checks++;
    if ({gnt, wr_en, din, owner, busy} !== {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held: gnt=%b wr_en=%b din=%h owner=%0d busy=%b, want all zero",
               gnt, wr_en, din, owner, busy);
    end
    req     = 4'b0000;
    reset_n = 1'b1;
    next_cycle();
    n_checks++;
    if ({gnt, busy} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b busy=%b, want 0000 0", gnt, busy);
    end
  endtask

  task automatic test_single_requester();
    logic [7:0] exp_d;
    do_reset();
    req  = 4'b0001;
    data = {24'h0, 8'hA1};
    #1;
    n_checks++;
    if ({gnt, wr_en} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL single_latency: gnt=%b wr_en=%b, want 0000 0", gnt, wr_en);
    end
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      exp_d = 8'(8'hA1 + i);
      data  = {24'h0, exp_d};
      #1;
      n_checks++;
      if ({gnt, wr_en, din, busy} !== {4'b0001, 1'b1, exp_d, 1'b1}) begin
        n_fail++;
        $display("FAIL single_beat%0d: gnt=%b wr_en=%b din=%h busy=%b, want 0001 1 %h 1",
                 i, gnt, wr_en, din, busy, exp_d);
      end
      next_cycle();
    end
    req = 4'b0000;
    #1;
    n_checks++;
    if ({gnt, wr_en} !== {4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b wr_en=%b, want 0001 0", gnt, wr_en);
    end
    next_cycle();
    n_checks++;
    if ({gnt, busy, owner} !== {4'b0000, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL single_idle: gnt=%b busy=%b owner=%0d, want 0000 0 0", gnt, busy, owner);
    end
  endtask

  task automatic test_all_requesting();
    logic [1:0] seq [5];
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req  = 4'b1111;
    data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    #1;
    next_cycle();
    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < B; b++) begin
        exp_g = 4'b0001 << seq[t];
        exp_d = 8'hB0 + {6'd0, seq[t]};
        n_checks++;
        if ({gnt, wr_en, din, owner} !== {exp_g, 1'b1, exp_d, seq[t]}) begin
          n_fail++;
          $display("FAIL all_req t%0d b%0d: gnt=%b wr_en=%b din=%h owner=%0d, want %b 1 %h %0d",
                   t, b, gnt, wr_en, din, owner, exp_g, exp_d, seq[t]);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    req  = 4'b0010;
    data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    #1;
    next_cycle();
    for (int b = 0; b < 2; b++) begin
      n_checks++;
      if ({gnt, wr_en, din} !== {4'b0010, 1'b1, 8'hC1}) begin
        n_fail++;
        $display("FAIL stall_pre%0d: gnt=%b wr_en=%b din=%h, want 0010 1 c1", b, gnt, wr_en, din);
      end
      next_cycle();
    end
    full = 1'b1;
    req  = 4'b1010;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++;
      if ({gnt, wr_en, din} !== {4'b0010, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: gnt=%b wr_en=%b din=%h, want 0010 0 00", s, gnt, wr_en, din);
      end
      next_cycle();
    end
    full = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      n_checks++;
      if ({gnt, wr_en, din} !== {4'b0010, 1'b1, 8'hC1}) begin
        n_fail++;
        $display("FAIL stall_post%0d: gnt=%b wr_en=%b din=%h, want 0010 1 c1", b, gnt, wr_en, din);
      end
      next_cycle();
    end
    n_checks++;
    if ({gnt, wr_en, din} !== {4'b1000, 1'b1, 8'hC3}) begin
      n_fail++;
      $display("FAIL stall_handover: gnt=%b wr_en=%b din=%h, want 1000 1 c3", gnt, wr_en, din);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req  = 4'b1100;
    data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    #1;
    next_cycle();
    n_checks++;
    if ({gnt, wr_en, din} !== {4'b0100, 1'b1, 8'hD2}) begin
      n_fail++;
      $display("FAIL early_beat: gnt=%b wr_en=%b din=%h, want 0100 1 d2", gnt, wr_en, din);
    end
    next_cycle();
    req = 4'b1000;
    #1;
    n_checks++;
    if ({gnt, wr_en, din} !== {4'b0100, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL early_drop: gnt=%b wr_en=%b din=%h, want 0100 0 00", gnt, wr_en, din);
    end
    next_cycle();
    n_checks++;
    if ({gnt, wr_en, din, owner} !== {4'b1000, 1'b1, 8'hD3, 2'd3}) begin
      n_fail++;
      $display("FAIL early_next: gnt=%b wr_en=%b din=%h owner=%0d, want 1000 1 d3 3",
               gnt, wr_en, din, owner);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req  = 4'b1000;
    data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    #1;
    next_cycle();
    for (int b = 0; b < 2; b++) begin
      n_checks++;
      if ({gnt, wr_en, din} !== {4'b1000, 1'b1, 8'hE3}) begin
        n_fail++;
        $display("FAIL rst_mid_beat%0d: gnt=%b wr_en=%b din=%h, want 1000 1 e3", b, gnt, wr_en, din);
      end
      if (b == 0) next_cycle();
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, wr_en, din, owner, busy} !== {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_drop: gnt=%b wr_en=%b din=%h owner=%0d busy=%b, want all zero",
               gnt, wr_en, din, owner, busy);
    end
    #2;
    req     = 4'b1001;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({gnt, wr_en} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_release: gnt=%b wr_en=%b, want 0000 0", gnt, wr_en);
    end
    next_cycle();
    n_checks++;
    if ({gnt, wr_en, din, owner} !== {4'b0001, 1'b1, 8'hE0, 2'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: gnt=%b wr_en=%b din=%h owner=%0d, want 0001 1 e0 0",
               gnt, wr_en, din, owner);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req  = 4'b0000;
    data = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
    #1;
    next_cycle();
    req = 4'b0110;
    #1;
    n_checks++;
    if ({gnt, wr_en} !== {4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL contend_idle: gnt=%b wr_en=%b, want 0000 0", gnt, wr_en);
    end
    next_cycle();
    for (int b = 0; b < B; b++) begin
      n_checks++;
      if ({gnt, wr_en, din, owner} !== {4'b0010, 1'b1, 8'hF1, 2'd1}) begin
        n_fail++;
        $display("FAIL contend_beat%0d: gnt=%b wr_en=%b din=%h owner=%0d, want 0010 1 f1 1",
                 b, gnt, wr_en, din, owner);
      end
      next_cycle();
    end
    n_checks++;
    if ({gnt, wr_en, din} !== {4'b0100, 1'b1, 8'hF2}) begin
      n_fail++;
      $display("FAIL contend_next: gnt=%b wr_en=%b din=%h, want 0100 1 f2", gnt, wr_en, din);
    end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_all_requesting();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_contention();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 8: the data word width in bits.
REQ-002 The block SHALL have parameter num_req, default 4: the number of write requesters, range 2..8.
REQ-003 The block SHALL have parameter burst, default 4: the maximum number of beats per grant tenure, 1..15.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_i, input, num_req bits: bit k high means requester k has a word to write.
REQ-007 The block SHALL have port data_i, input, num_req*width bits: requester k's word on bits [k*width +: width].
REQ-008 The block SHALL have port gnt_o, output, num_req bits: one-hot or zero; the current owner of the FIFO write port.
REQ-009 The block SHALL have port full_i, input, 1 bit: full flag from the FIFO.
REQ-010 The block SHALL have port wr_en_o, output, 1 bit: FIFO write enable.
REQ-011 The block SHALL have port din_o, output, width bits: FIFO write data.
REQ-012 The block SHALL have port owner_o, output, clog2(num_req) bits: the index of the current owner, 0 when idle.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high while in GRANT state.

Function
REQ-014 The block SHALL use a two-state FSM: IDLE (no owner) and GRANT (one owner). gnt_o, owner_o and busy_o are registered from FSM state.
REQ-015 In IDLE, if any req_i bit is high, the block SHALL select the owner round-robin and enter GRANT at the next edge, so gnt_o rises one cycle after req_i.
REQ-016 Round-robin search SHALL start at index (last_owner+1) mod num_req and wrap; after reset, last_owner SHALL be num_req-1, so requester 0 has first priority.
REQ-017 A beat SHALL be accepted in a cycle exactly when state=GRANT, req_i[owner]=1 and full_i=0.
REQ-018 wr_en_o SHALL be combinational and equal to beat-accepted; din_o SHALL equal data_i[owner] when wr_en_o=1, else 0.
REQ-019 The beat counter SHALL increment only on accepted beats; full_i=1 SHALL stall the tenure with the grant held and the count frozen.
REQ-020 A tenure SHALL end at the edge where either (a) the accepted beat brings the count to burst, or (b) req_i[owner]=0.
REQ-021 At tenure end, last_owner SHALL be updated to the owner. If any other request is pending, or the owner's request is still pending, the block SHALL re-arbitrate in the same cycle and load the new owner with no idle gap. Otherwise it SHALL return to IDLE.
REQ-022 The beat counter SHALL clear on every new tenure.
REQ-023 If the owner still requests at a burst end and no other requester is active, the owner SHALL be re-granted immediately.
REQ-024 Requests arriving mid-tenure SHALL NOT preempt the owner.
REQ-025 At most one gnt_o bit SHALL be high, and at most one beat SHALL be written per cycle.

Reset
REQ-026 On reset_n_i low, the block SHALL immediately and asynchronously set state=IDLE, gnt_o=0, owner_o=0, busy_o=0, beat count=0, last_owner=num_req-1. As a result, wr_en_o=0 and din_o=0.
REQ-027 A reset asserted mid-burst SHALL abandon the tenure with no further write. After release, arbitration SHALL restart from requester 0.

Verification
REQ-028 Scenario 1 (single requester): req_i=0001 held, data 0xA1..0xA6, full_i=0. Required: gnt_o=0001 one cycle later; 4 writes; 0 idle cycles; 2 more writes; gnt_o stays 0001.
REQ-029 Scenario 2 (all requesting): req_i=1111 held continuously. Required: owners 0,1,2,3,0 in order, 4 beats each, no gap cycles between tenures.
REQ-030 Scenario 3 (full stall): full_i=1 asserted for 3 cycles after beat 2 of requester 1. Required: wr_en_o=0 for those 3 cycles, gnt_o held at 0010, beats 3-4 written after full_i drops.
REQ-031 Scenario 4 (early release): requester 2 drops req_i after 1 beat while requester 3 is waiting. Required: gnt_o moves to 1000 at the next edge; exactly 1 beat written by requester 2.
REQ-032 Scenario 5 (reset mid-burst): reset_n_i pulsed low during beat 2 of requester 3. Required: wr_en_o and gnt_o drop in the same cycle; after release with req_i=1001, requester 0 is granted first.
REQ-033 Scenario 6 (contention): req_i rises from 0000 to 0110 in one cycle. Required: requester 1 is granted; din_o equals data_i[1]; no bit of gnt_o other than bit 1 is ever high during that tenure.
